// File: rtl/word_assembler_if.sv
// ---------------------------------------------------------------------------
// word_assembler_if
//   Bundles the byte-side and word-side handshakes of word_assembler.
//
//   Handshake semantics (both sides): a transfer happens on a rising clock
//   edge where valid && ready are both high. A source holding valid high may
//   not retract or change its payload until the transfer happens. ready may
//   depend combinationally on the other side's ready, never on valid.
//
//   Signals
//     in_byte   [BYTE_W]  byte offered by the producer
//     in_valid            in_byte / in_last are meaningful
//     in_last             this byte closes the current word (short flush)
//     in_ready            assembler takes the byte on this edge
//     out_word  [DATA_W]  assembled word
//     out_bytes [3]       number of valid bytes in out_word (1..NLANES)
//     out_valid           out_word / out_bytes are meaningful
//     out_ready           consumer takes the word on this edge
//     state_dbg           1 while a finished word is held for the consumer
//
//   Modports
//     master : producer/consumer side (drives in_*, out_ready)
//     slave  : the assembler itself
// ---------------------------------------------------------------------------
interface word_assembler_if #(
  parameter int BYTE_W = 8,
  parameter int DATA_W = 32
);
  logic [BYTE_W-1:0] in_byte;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [DATA_W-1:0] out_word;
  logic [2:0]        out_bytes;
  logic              out_valid;
  logic              out_ready;
  logic              state_dbg;

  modport master (
    output in_byte, in_valid, in_last, out_ready,
    input  in_ready, out_word, out_bytes, out_valid, state_dbg
  );

  modport slave (
    input  in_byte, in_valid, in_last, out_ready,
    output in_ready, out_word, out_bytes, out_valid, state_dbg
  );
endinterface

// File: rtl/word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
//   Packs a byte stream into DATA_W-bit words. Bytes fill lanes of a single
//   word register; when the last lane is written or in_last is seen, the word
//   is presented on the output and held until the consumer takes it. While a
//   word is held, input is accepted only on the same edge the word leaves,
//   so there is never more than one word in flight.
//
//   Ports
//     clk    : clock, all state changes on the rising edge
//     reset  : asynchronous, active-high; drops any partial word
//     bus    : word_assembler_if.slave (byte input / word output handshakes)
//
//   Parameters
//     DATA_W    : output word width, must equal NLANES*BYTE_W
//     BYTE_W    : input byte width
//     NLANES    : bytes per word
//     LSB_FIRST : 1 -> byte k lands in bits [BYTE_W*k +: BYTE_W]
//                 0 -> byte 0 lands in the most significant lane
// ---------------------------------------------------------------------------
module word_assembler #(
  parameter int DATA_W    = 32,
  parameter int BYTE_W    = 8,
  parameter int NLANES    = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  word_assembler_if.slave   bus
);

  localparam int IDX_W = (NLANES > 1) ? $clog2(NLANES) : 1;

  typedef enum logic {
    S_FILL = 1'b0,  // collecting bytes, output not valid
    S_HOLD = 1'b1   // finished word presented, waiting for consumer
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;     // arrival order of the next byte
  logic [DATA_W-1:0] word_q,  word_d;
  logic [2:0]        bytes_q, bytes_d;

  logic in_ready;
  logic in_beat;
  logic out_beat;

  // Physical lane for the byte that arrives in position i of the word.
  function automatic logic [IDX_W-1:0] lane_of(input logic [IDX_W-1:0] i);
    if (LSB_FIRST != 0) begin
      return i;
    end else begin
      return IDX_W'(NLANES - 1) - i;
    end
  endfunction

  // Returns w with lane 'lane' replaced by b. Constant-index loop keeps the
  // write a plain mux per lane.
  function automatic logic [DATA_W-1:0] put_lane(
    input logic [DATA_W-1:0] w,
    input logic [IDX_W-1:0]  lane,
    input logic [BYTE_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    r = w;
    for (int k = 0; k < NLANES; k++) begin
      if (lane == IDX_W'(k)) begin
        r[k*BYTE_W +: BYTE_W] = b;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    bytes_d = bytes_q;

    // Depends only on state and the consumer, never on in_valid/in_byte.
    in_ready = (state_q == S_FILL) || bus.out_ready;
    in_beat  = bus.in_valid && in_ready;
    out_beat = (state_q == S_HOLD) && bus.out_ready;

    case (state_q)
      S_FILL: begin
        if (in_beat) begin
          // The first byte of a word clears the other lanes so a short word
          // comes out zero-padded, whatever the register held before.
          word_d = put_lane((idx_q == {IDX_W{1'b0}}) ? {DATA_W{1'b0}} : word_q,
                            lane_of(idx_q), bus.in_byte);
          if (bus.in_last || (idx_q == IDX_W'(NLANES - 1))) begin
            state_d = S_HOLD;
            bytes_d = 3'(idx_q) + 3'd1;
            idx_d   = {IDX_W{1'b0}};
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S_HOLD: begin
        if (out_beat) begin
          if (in_beat) begin
            // Word leaves and a new one starts on the same edge.
            word_d = put_lane({DATA_W{1'b0}}, lane_of({IDX_W{1'b0}}), bus.in_byte);
            if (bus.in_last || (NLANES == 1)) begin
              // One-byte word completes immediately; stay presenting.
              bytes_d = 3'd1;
              idx_d   = {IDX_W{1'b0}};
            end else begin
              state_d = S_FILL;
              idx_d   = IDX_W'(1);
            end
          end else begin
            // Word register keeps its contents; out_valid=0 makes it moot.
            state_d = S_FILL;
            idx_d   = {IDX_W{1'b0}};
          end
        end
      end

      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FILL;
      idx_q   <= {IDX_W{1'b0}};
      word_q  <= {DATA_W{1'b0}};
      bytes_q <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      bytes_q <= bytes_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_word  = word_q;
  assign bus.out_bytes = bytes_q;
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.state_dbg = (state_q == S_HOLD);

endmodule

// File: tb/tb_word_assembler.sv
// ---------------------------------------------------------------------------
// tb_word_assembler
//   Two assemblers (LSB-first and MSB-first lane order) share one input
//   stream and one out_ready. A word-level reference model groups accepted
//   bytes into words (NLANES bytes or up to in_last) and queues the expected
//   word for both lane orders; every cycle the outputs are compared to the
//   head of that queue.
// ---------------------------------------------------------------------------
module tb_word_assembler;

  localparam int BYTE_W = 8;
  localparam int DATA_W = 32;
  localparam int NLANES = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  word_assembler_if #(.BYTE_W(BYTE_W), .DATA_W(DATA_W)) bus_l ();
  word_assembler_if #(.BYTE_W(BYTE_W), .DATA_W(DATA_W)) bus_m ();

  word_assembler #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .NLANES(NLANES), .LSB_FIRST(1))
    dut_l (.clk(clk), .reset(reset), .bus(bus_l));
  word_assembler #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .NLANES(NLANES), .LSB_FIRST(0))
    dut_m (.clk(clk), .reset(reset), .bus(bus_m));

  logic [BYTE_W-1:0] drv_byte  = '0;
  logic              drv_valid = 1'b0;
  logic              drv_last  = 1'b0;
  logic              drv_ready = 1'b0;

  assign bus_l.in_byte   = drv_byte;
  assign bus_l.in_valid  = drv_valid;
  assign bus_l.in_last   = drv_last;
  assign bus_l.out_ready = drv_ready;
  assign bus_m.in_byte   = drv_byte;
  assign bus_m.in_valid  = drv_valid;
  assign bus_m.in_last   = drv_last;
  assign bus_m.out_ready = drv_ready;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] exp_q[$];      // expected words, LSB-first order
  logic [DATA_W-1:0] exp_m_q[$];    // same words, MSB-first order
  int                exp_cnt_q[$];  // expected out_bytes
  logic [BYTE_W-1:0] cur_q[$];      // bytes of the word being collected

  int                acc_cnt   = 0; // bytes accepted (model view)
  int                pop_cnt   = 0; // words taken by the consumer
  int                bytes_out = 0; // sum of out_bytes over taken words
  int                bubbles   = 0;
  bit                nb_win    = 1'b0;
  logic [DATA_W-1:0] last_l, last_m;
  int                last_cnt  = 0;

  logic [DATA_W-1:0] wl, wm;
  bit                exp_valid, exp_rdy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- monitor + reference model ----------------
  // Runs on the falling edge: inputs are stable, registered outputs settled.
  // The model update below represents what the next rising edge commits.
  always @(negedge clk) begin
    if (!reset) begin
      exp_valid = (exp_q.size() != 0);
      exp_rdy   = !exp_valid || drv_ready;

      check_eq("out_valid_l", {31'b0, bus_l.out_valid}, {31'b0, exp_valid});
      check_eq("out_valid_m", {31'b0, bus_m.out_valid}, {31'b0, exp_valid});
      check_eq("in_ready_l",  {31'b0, bus_l.in_ready},  {31'b0, exp_rdy});
      check_eq("in_ready_m",  {31'b0, bus_m.in_ready},  {31'b0, exp_rdy});
      check_eq("hold_dbg_l",  {31'b0, bus_l.state_dbg}, {31'b0, exp_valid});

      if (exp_valid) begin
        check_eq("word_l",  bus_l.out_word, exp_q[0]);
        check_eq("word_m",  bus_m.out_word, exp_m_q[0]);
        check_eq("bytes_l", {29'b0, bus_l.out_bytes}, exp_cnt_q[0]);
        check_eq("bytes_m", {29'b0, bus_m.out_bytes}, exp_cnt_q[0]);
      end

      if (nb_win && drv_valid && !bus_l.in_ready) bubbles++;

      if (exp_valid && drv_ready) begin
        last_l    = bus_l.out_word;
        last_m    = bus_m.out_word;
        last_cnt  = int'(bus_l.out_bytes);
        bytes_out = bytes_out + int'(bus_l.out_bytes);
        pop_cnt++;
        void'(exp_q.pop_front());
        void'(exp_m_q.pop_front());
        void'(exp_cnt_q.pop_front());
      end

      if (drv_valid && exp_rdy) begin
        cur_q.push_back(drv_byte);
        acc_cnt++;
        if (drv_last || cur_q.size() == NLANES) begin
          wl = '0;
          wm = '0;
          for (int k = 0; k < cur_q.size(); k++) begin
            wl[BYTE_W*k +: BYTE_W]              = cur_q[k];
            wm[BYTE_W*(NLANES-1-k) +: BYTE_W]   = cur_q[k];
          end
          exp_q.push_back(wl);
          exp_m_q.push_back(wm);
          exp_cnt_q.push_back(cur_q.size());
          cur_q.delete();
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; sets inputs for one cycle and returns at the next
  // posedge+1.
  task automatic drive(input logic [7:0] b, input bit v, input bit l, input bit r);
    drv_byte  = b;
    drv_valid = v;
    drv_last  = l;
    drv_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send4(input logic [31:0] bytes_lsb, input bit last4, input bit r);
    logic [31:0] v;
    v = bytes_lsb;
    for (int i = 0; i < 4; i++) drive(v[8*i +: 8], 1'b1, (i == 3) && last4, r);
  endtask

  // Asserts reset between clock edges, checks the cleared outputs, releases.
  task automatic do_reset();
    #2;
    reset     = 1'b1;
    drv_valid = 1'b0;
    drv_last  = 1'b0;
    cur_q.delete();
    exp_q.delete();
    exp_m_q.delete();
    exp_cnt_q.delete();
    #1;
    check_eq("rst_valid_l", {31'b0, bus_l.out_valid}, 32'd0);
    check_eq("rst_word_l",  bus_l.out_word, 32'd0);
    check_eq("rst_word_m",  bus_m.out_word, 32'd0);
    check_eq("rst_bytes_l", {29'b0, bus_l.out_bytes}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int base_pop, base_acc, base_out, cyc;

  initial begin
    // reset state
    #2;
    check_eq("init_valid_l", {31'b0, bus_l.out_valid}, 32'd0);
    check_eq("init_word_l",  bus_l.out_word, 32'd0);
    check_eq("init_bytes_l", {29'b0, bus_l.out_bytes}, 32'd0);
    check_eq("init_ready_l", {31'b0, bus_l.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // 1: full word, consumer always ready
    send4(32'hA213D22F, 1'b0, 1'b1);
    idle(3);
    check_eq("t1_word_l",  last_l, 32'hA213D22F);
    check_eq("t1_word_m",  last_m, 32'h2FD213A2);
    check_eq("t1_bytes",   last_cnt, 4);

    // 2: consumer stalls 5 cycles while next byte is offered
    send4(32'hA213D22F, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(8'h11, 1'b1, 1'b0, 1'b0);
      check_eq("t2_hold_word", bus_l.out_word, 32'hA213D22F);
      check_eq("t2_hold_rdy",  {31'b0, bus_l.in_ready}, 32'd0);
    end
    drive(8'h11, 1'b1, 1'b0, 1'b1);
    check_eq("t2_released", last_l, 32'hA213D22F);
    drive(8'h22, 1'b1, 1'b0, 1'b1);
    drive(8'h33, 1'b1, 1'b0, 1'b1);
    drive(8'h44, 1'b1, 1'b0, 1'b1);
    idle(3);
    check_eq("t2_next_word", last_l, 32'h44332211);

    // 3: short word, then 8 back-to-back words
    drive(8'hBC, 1'b1, 1'b0, 1'b1);
    drive(8'h3A, 1'b1, 1'b1, 1'b1);
    idle(3);
    check_eq("t3_short_l",  last_l, 32'h00003ABC);
    check_eq("t3_short_m",  last_m, 32'hBC3A0000);
    check_eq("t3_short_n",  last_cnt, 2);
    base_pop = pop_cnt;
    bubbles  = 0;
    nb_win   = 1'b1;
    for (int i = 0; i < 32; i++) drive(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b1);
    nb_win   = 1'b0;
    idle(3);
    check_eq("t3_bubbles", bubbles, 0);
    check_eq("t3_words",   pop_cnt - base_pop, 8);

    // in_last on the fourth byte behaves like a normal completion
    base_pop = pop_cnt;
    send4(32'h04030201, 1'b1, 1'b1);
    idle(3);
    check_eq("last4_words", pop_cnt - base_pop, 1);
    check_eq("last4_word",  last_l, 32'h04030201);
    check_eq("last4_bytes", last_cnt, 4);

    // one-byte word started on the same edge the held word leaves
    send4(32'hF0DEBC9A, 1'b0, 1'b0);
    drive(8'h77, 1'b1, 1'b1, 1'b1);
    check_eq("oneb_prev", last_l, 32'hF0DEBC9A);
    check_eq("oneb_valid", {31'b0, bus_l.out_valid}, 32'd1);
    idle(2);
    check_eq("oneb_word_l", last_l, 32'h00000077);
    check_eq("oneb_word_m", last_m, 32'h77000000);
    check_eq("oneb_bytes",  last_cnt, 1);

    // 4: async reset mid-word, then one clean word
    drive(8'h5A, 1'b1, 1'b0, 1'b1);
    drive(8'hC3, 1'b1, 1'b0, 1'b1);
    do_reset();
    base_pop = pop_cnt;
    send4(32'h3324DFA1, 1'b0, 1'b1);
    idle(3);
    check_eq("t4_words",  pop_cnt - base_pop, 1);
    check_eq("t4_word_l", last_l, 32'h3324DFA1);

    // 5: MSB-first order (dut_m) on the same stream
    check_eq("t5_word_m", last_m, 32'hA1DF2433);
    drive(8'h55, 1'b1, 1'b1, 1'b1);
    idle(3);
    check_eq("t5_short_m", last_m, 32'h55000000);
    check_eq("t5_short_l", last_l, 32'h00000055);
    check_eq("t5_short_n", last_cnt, 1);

    // 6: randomized traffic
    base_acc = acc_cnt;
    base_out = bytes_out;
    cyc      = 0;
    while ((acc_cnt - base_acc) < 10000 && cyc < 40000) begin
      drive(8'($urandom_range(0, 255)),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) < 7));
      cyc++;
    end
    check_eq("t6_budget", {31'b0, ((acc_cnt - base_acc) >= 10000)}, 32'd1);
    // flush whatever partial word the model still holds
    cyc = acc_cnt;
    for (int i = 0; i < 20 && acc_cnt == cyc; i++) drive(8'hE7, 1'b1, 1'b1, 1'b1);
    check_eq("t6_flush", acc_cnt - cyc, 1);
    idle(4);
    check_eq("t6_drained", exp_q.size(), 0);
    check_eq("t6_partial", cur_q.size(), 0);
    check_eq("t6_bytes",   bytes_out - base_out, acc_cnt - base_acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
